gmii_rx_deframer: RTL and testbench

- Receive-side framing stage that sits directly downstream of the RGMII PHY interface in the `mac_gmii_rx_clk` domain.
- Consumes the GMII receive signals (`rxd`, `dv`, `er`). At 10/100 these carry one nibble per cycle on `rxd[3:0]`; at 1000 they carry one byte per cycle.
- Strips preamble and SFD, reassembles nibbles into bytes, and emits a byte-wide AXI-stream frame. `tlast` marks end of frame; `tuser` marks bad frames.
- Produces per-frame status pulses for the MAC statistics block.

---
 rtl/gmii_rx_deframer.sv | 167 ++++++++++++++++
 tb/tb_gmii_rx_deframer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_deframer.sv
`timescale 1ns/1ps
// gmii_rx_deframer: GMII receive framing stage.
// Strips preamble/SFD, packs nibbles, emits a byte AXI-stream plus status.
module gmii_rx_deframer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [1:0] speed,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_rx_good_frame,
  output logic       stat_rx_bad_frame,
  output logic       stat_rx_framing_err
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    PAY,
    DROP
  } state_t;

  state_t      state;
  logic        armed;
  logic        nib;
  logic        phase;
  logic        hold_vld;
  logic        err;
  logic [3:0]  lo;
  logic [7:0]  hold;
  logic [15:0] len;

  logic        nib_live;
  logic        is_pre;
  logic        is_sfd;
  logic        sof;
  logic        bad;
  logic [7:0]  byte_new;
  logic [15:0] len_inc;

  assign nib_live = (speed != 2'b10);

  always_comb begin
    is_pre   = nib_live ? (gmii_rxd[3:0] == 4'h5)
                        : (gmii_rxd == 8'h55);
    is_sfd   = nib_live ? (gmii_rxd[3:0] == 4'hD)
                        : (gmii_rxd == 8'hD5);
    byte_new = nib ? {gmii_rxd[3:0], lo} : gmii_rxd;
    len_inc  = (len == 16'hFFFF) ? len : len + 16'd1;
    bad      = err | phase
             | (len < MIN_LEN) | (len > MAX_LEN);
    // nibble SFD is only legal after a preamble nibble, i.e. from PRE
    sof      = gmii_rx_dv & armed & is_sfd
             & (((state == IDLE) & ~nib_live)
             | ((state == PRE) & ~gmii_rx_er));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      armed               <= 1'b0;
      nib                 <= 1'b0;
      phase               <= 1'b0;
      hold_vld            <= 1'b0;
      err                 <= 1'b0;
      lo                  <= 4'h0;
      hold                <= 8'h00;
      len                 <= 16'h0;
      m_axis_tdata        <= 8'h00;
      m_axis_tvalid       <= 1'b0;
      m_axis_tlast        <= 1'b0;
      m_axis_tuser        <= 1'b0;
      stat_rx_good_frame  <= 1'b0;
      stat_rx_bad_frame   <= 1'b0;
      stat_rx_framing_err <= 1'b0;
    end else begin
      m_axis_tvalid       <= 1'b0;
      m_axis_tlast        <= 1'b0;
      m_axis_tuser        <= 1'b0;
      stat_rx_good_frame  <= 1'b0;
      stat_rx_bad_frame   <= 1'b0;
      stat_rx_framing_err <= 1'b0;

      // a frame already in flight at reset release is never entered
      if (!gmii_rx_dv) armed <= 1'b1;

      unique case (state)
        IDLE: begin
          if (gmii_rx_dv) begin
            if (!armed)      state <= DROP;
            else if (is_pre) state <= PRE;
            else if (sof)    state <= PAY;
            else             state <= DROP;
          end
        end
        PRE: begin
          if (!gmii_rx_dv) begin
            state               <= IDLE;
            stat_rx_framing_err <= 1'b1;
          end else if (gmii_rx_er) begin
            state               <= DROP;
            stat_rx_framing_err <= 1'b1;
          end else if (is_sfd) begin
            state <= PAY;
          end else if (!is_pre) begin
            state               <= DROP;
            stat_rx_framing_err <= 1'b1;
          end
        end
        PAY: begin
          if (gmii_rx_dv) begin
            if (gmii_rx_er) err <= 1'b1;
            if (nib && !phase) begin
              lo    <= gmii_rxd[3:0];
              phase <= 1'b1;
            end else begin
              phase    <= 1'b0;
              hold     <= byte_new;
              hold_vld <= 1'b1;
              len      <= len_inc;
              if (hold_vld) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= hold;
              end
            end
          end else begin
            state    <= IDLE;
            hold_vld <= 1'b0;
            phase    <= 1'b0;
            if (hold_vld) begin
              m_axis_tvalid      <= 1'b1;
              m_axis_tdata       <= hold;
              m_axis_tlast       <= 1'b1;
              m_axis_tuser       <= bad;
              stat_rx_good_frame <= ~bad;
              stat_rx_bad_frame  <= bad;
            end else begin
              stat_rx_bad_frame <= 1'b1;
            end
          end
        end
        DROP: begin
          if (!gmii_rx_dv) state <= IDLE;
        end
      endcase

      if (sof) begin
        nib      <= nib_live;
        len      <= 16'h0;
        err      <= 1'b0;
        phase    <= 1'b0;
        hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
`timescale 1ns/1ps
// tb_gmii_rx_deframer: directed and randomized frames against a
// frame-level reference model of the deframer.
module tb_gmii_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gmii_rxd = 8'h00;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_er = 1'b0;
  logic [1:0] speed = 2'b10;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       stat_rx_good_frame;
  logic       stat_rx_bad_frame;
  logic       stat_rx_framing_err;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         c;
  } beat_t;

  beat_t      mon_q[$];
  beat_t      exp_q[$];
  int         mon_good[$];
  int         exp_good[$];
  int         mon_bad[$];
  int         exp_bad[$];
  int         mon_fe[$];
  int         exp_fe[$];
  logic [7:0] pay[$];

  gmii_rx_deframer dut (
    .clk                 (clk),
    .rst                 (rst),
    .gmii_rxd            (gmii_rxd),
    .gmii_rx_dv          (gmii_rx_dv),
    .gmii_rx_er          (gmii_rx_er),
    .speed               (speed),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tuser        (m_axis_tuser),
    .stat_rx_good_frame  (stat_rx_good_frame),
    .stat_rx_bad_frame   (stat_rx_bad_frame),
    .stat_rx_framing_err (stat_rx_framing_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    if (m_axis_tvalid) begin
      b.d = m_axis_tdata;
      b.l = m_axis_tlast;
      b.u = m_axis_tuser;
      b.c = cyc;
      mon_q.push_back(b);
    end
    if (stat_rx_good_frame)  mon_good.push_back(cyc);
    if (stat_rx_bad_frame)   mon_bad.push_back(cyc);
    if (stat_rx_framing_err) mon_fe.push_back(cyc);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  // one GMII sample; c is the cycle the DUT samples it in
  task automatic drive(input logic v, input logic e,
                       input logic [7:0] d, output int c);
    @(posedge clk);
    #1;
    gmii_rx_dv = v;
    gmii_rx_er = e;
    gmii_rxd   = d;
    c          = cyc;
  endtask

  task automatic idle(input int n);
    int c;
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      r = 8'($urandom);
      drive(1'b0, r[0], r, c);
    end
  endtask

  task automatic fill(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  // sends pay[] as a frame and records what the spec says must come out
  task automatic send_frame(input logic [1:0] spd, input int npre,
                            input int er_at, input bit odd,
                            input bit flip);
    int ct[$];
    int c;
    int f;
    int nb;
    bit nib;
    bit bad;
    bit last;
    logic [7:0] r;
    beat_t b;
    nib   = (spd != 2'b10);
    nb    = pay.size();
    speed = spd;
    r     = 8'($urandom);
    for (int i = 0; i < npre; i++) begin
      r = 8'($urandom);
      drive(1'b1, 1'b0, nib ? {r[7:4], 4'h5} : 8'h55, c);
    end
    drive(1'b1, 1'b0, nib ? {r[7:4], 4'hD} : 8'hD5, c);
    for (int k = 0; k < nb; k++) begin
      r = 8'($urandom);
      if (nib) begin
        drive(1'b1, k == er_at, {r[7:4], pay[k][3:0]}, c);
        drive(1'b1, 1'b0, {r[3:0], pay[k][7:4]}, c);
      end else begin
        drive(1'b1, k == er_at, pay[k], c);
      end
      ct.push_back(c);
      if (flip && k == 0) speed = nib ? 2'b10 : 2'b01;
    end
    if (odd) begin
      r = 8'($urandom);
      drive(1'b1, 1'b0, r, c);
    end
    r = 8'($urandom);
    drive(1'b0, r[0], r, f);
    bad = (er_at >= 0 && er_at < nb) || nb < 64
       || nb > 1518 || odd;
    if (nb == 0) begin
      exp_bad.push_back(f + 1);
    end else begin
      for (int k = 0; k < nb; k++) begin
        last = (k == nb - 1);
        b.d  = pay[k];
        b.l  = last;
        b.u  = last ? bad : 1'b0;
        b.c  = last ? f + 1 : (nib ? ct[k] + 3 : ct[k] + 2);
        exp_q.push_back(b);
      end
      if (bad) exp_bad.push_back(f + 1);
      else     exp_good.push_back(f + 1);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    chk({tag, ".nbeats"}, mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".tdata"}, mon_q[i].d, exp_q[i].d);
      chk({tag, ".tlast"}, mon_q[i].l, exp_q[i].l);
      chk({tag, ".tuser"}, mon_q[i].u, exp_q[i].u);
      chk({tag, ".cycle"}, mon_q[i].c, exp_q[i].c);
    end
    chk({tag, ".ngood"}, mon_good.size(), exp_good.size());
    for (int i = 0; i < mon_good.size() && i < exp_good.size(); i++)
      chk({tag, ".good_cyc"}, mon_good[i], exp_good[i]);
    chk({tag, ".nbad"}, mon_bad.size(), exp_bad.size());
    for (int i = 0; i < mon_bad.size() && i < exp_bad.size(); i++)
      chk({tag, ".bad_cyc"}, mon_bad[i], exp_bad[i]);
    chk({tag, ".nfe"}, mon_fe.size(), exp_fe.size());
    for (int i = 0; i < mon_fe.size() && i < exp_fe.size(); i++)
      chk({tag, ".fe_cyc"}, mon_fe[i], exp_fe[i]);
    mon_q.delete();
    exp_q.delete();
    mon_good.delete();
    exp_good.delete();
    mon_bad.delete();
    exp_bad.delete();
    mon_fe.delete();
    exp_fe.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, ".tlast"}, m_axis_tlast, 1'b0);
    chk({tag, ".tuser"}, m_axis_tuser, 1'b0);
    chk({tag, ".tdata"}, m_axis_tdata, 8'h00);
    chk({tag, ".good"}, stat_rx_good_frame, 1'b0);
    chk({tag, ".bad"}, stat_rx_bad_frame, 1'b0);
    chk({tag, ".fe"}, stat_rx_framing_err, 1'b0);
  endtask

  initial begin
    int c;
    int o;
    int len;
    int er_at;
    logic [1:0] s;
    bit nib;
    beat_t b;

    // reset state
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(3);

    // 1000M, 7 preamble bytes, 0x00..0x3F payload
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i));
    send_frame(2'b10, 7, -1, 1'b0, 1'b0);
    idle(4);
    check_all("g1000");

    // 100M, 15 preamble nibbles, bytes 0x10, 0x01, padded to 64
    fill(62);
    pay.push_front(8'h01);
    pay.push_front(8'h10);
    send_frame(2'b01, 15, -1, 1'b0, 1'b0);
    idle(4);
    check_all("g100");

    // er on byte 20, then a 10-byte runt
    fill(64);
    send_frame(2'b10, 7, 20, 1'b0, 1'b0);
    idle(2);
    fill(10);
    send_frame(2'b10, 7, -1, 1'b0, 1'b0);
    idle(4);
    check_all("er_runt");

    // 10M odd nibble count: 128 nibbles plus one dangling
    fill(64);
    send_frame(2'b00, 15, -1, 1'b1, 1'b0);
    idle(4);
    check_all("odd");

    // 1000M 0x55, 0x57: framing error, rest dropped
    speed = 2'b10;
    drive(1'b1, 1'b0, 8'h55, c);
    drive(1'b1, 1'b0, 8'h57, o);
    exp_fe.push_back(o + 1);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'($urandom), c);
    drive(1'b0, 1'b0, 8'h00, c);
    // preamble cut by dv falling: framing error too
    drive(1'b1, 1'b0, 8'h55, c);
    drive(1'b1, 1'b0, 8'h55, c);
    drive(1'b0, 1'b0, 8'h00, o);
    exp_fe.push_back(o + 1);
    // nibble mode: 0xD as first nibble is dropped silently
    speed = 2'b01;
    drive(1'b1, 1'b0, 8'h0D, c);
    drive(1'b1, 1'b0, 8'h05, c);
    drive(1'b1, 1'b0, 8'h0D, c);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom), c);
    drive(1'b0, 1'b0, 8'h00, c);
    idle(4);
    check_all("framing");

    // reset at payload byte 30, released while dv stays high
    fill(64);
    speed = 2'b10;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, c);
    drive(1'b1, 1'b0, 8'hD5, c);
    for (int k = 0; k < 30; k++) drive(1'b1, 1'b0, pay[k], c);
    drive(1'b1, 1'b0, pay[30], o);
    rst = 1'b1;
    for (int k = 0; k < 29; k++) begin
      b.d = pay[k];
      b.l = 1'b0;
      b.u = 1'b0;
      b.c = o - 30 + k + 2;
      if (b.c <= o) exp_q.push_back(b);
    end
    drive(1'b1, 1'b0, pay[31], c);
    @(negedge clk);
    chk_zero("midrst");
    drive(1'b1, 1'b0, pay[32], c);
    rst = 1'b0;
    for (int k = 33; k < 64; k++) drive(1'b1, 1'b0, pay[k], c);
    drive(1'b0, 1'b0, 8'h00, c);
    idle(4);
    check_all("rstframe");
    fill(70);
    send_frame(2'b10, 7, -1, 1'b0, 1'b0);
    idle(4);
    check_all("after_rst");

    // zero-byte frames in both modes
    fill(0);
    send_frame(2'b10, 7, -1, 1'b0, 1'b0);
    idle(2);
    send_frame(2'b01, 3, -1, 1'b0, 1'b0);
    idle(4);
    check_all("zero");

    // oversize
    fill(1600);
    send_frame(2'b10, 7, -1, 1'b0, 1'b0);
    idle(4);
    check_all("giant");

    // random back-to-back pairs, one dv=0 cycle apart
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p < 2; p++) begin
        s     = 2'($urandom_range(0, 2));
        nib   = (s != 2'b10);
        len   = $urandom_range(58, 90);
        er_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
        fill(len);
        send_frame(s, nib ? $urandom_range(1, 15) : $urandom_range(0, 7),
                   er_at, nib && ($urandom_range(0, 2) == 0),
                   $urandom_range(0, 1) == 1);
      end
      idle(4);
      check_all("rand");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
